// File: rtl/sipo_reg_pkg.sv
// -----------------------------------------------------------------------------
// sipo_reg_pkg
//   Shared constants for the serial-in, parallel-out shift register.
//   Holds only the default register width used when no WIDTH override is given.
// -----------------------------------------------------------------------------
package sipo_reg_pkg;

    localparam int SIPO_DEFAULT_WIDTH = 4;

endpackage : sipo_reg_pkg

// File: rtl/sipo_reg.sv
// -----------------------------------------------------------------------------
// sipo_reg
//   Serial-in, parallel-out shift register. One serial bit is captured on every
//   rising clock edge and the most recent WIDTH bits are presented as a
//   parallel word. There is no enable, framing or valid signalling; the
//   consumer samples po whenever it needs to.
//
// Parameters
//   WIDTH       : number of stages and width of po (>= 2)
//   SHIFT_LEFT  : 1 -> new bit enters po[0], older bits move toward po[WIDTH-1]
//                 0 -> new bit enters po[WIDTH-1], older bits move toward po[0]
//   RESET_VALUE : value loaded into po by reset
//
// Ports
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset, has priority over shifting
//   si  : serial data in, sampled on every rising edge
//   po  : parallel data out, driven straight from the shift register flops
// -----------------------------------------------------------------------------
module sipo_reg
    import sipo_reg_pkg::*;
#(
    parameter int               WIDTH       = SIPO_DEFAULT_WIDTH,
    parameter bit               SHIFT_LEFT  = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    output logic [WIDTH-1:0] po
);

    // The oldest bit falls off the far end; nothing wraps around.
    always_ff @(posedge clk) begin
        if (rst) begin
            po <= RESET_VALUE;
        end else if (SHIFT_LEFT) begin
            po <= {po[WIDTH-2:0], si};
        end else begin
            po <= {si, po[WIDTH-1:1]};
        end
    end

endmodule : sipo_reg

// File: tb/tb_sipo_reg.sv
// -----------------------------------------------------------------------------
// tb_sipo_reg
//   Directed bench for sipo_reg. Two instances share the clock:
//     dut4 : WIDTH=4, SHIFT_LEFT=1 (default configuration)
//     dut8 : WIDTH=8, SHIFT_LEFT=0 (parameter variant)
//   Inputs change on the falling edge; outputs are sampled 1 ns after the
//   rising edge. Expected words are hand-computed tables.
// -----------------------------------------------------------------------------
module tb_sipo_reg;

    logic       clk = 1'b0;
    logic       rst4;
    logic       si4;
    logic [3:0] po4;
    logic       rst8;
    logic       si8;
    logic [7:0] po8;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sipo_reg #(
        .WIDTH      (4),
        .SHIFT_LEFT (1'b1),
        .RESET_VALUE(4'b0000)
    ) dut4 (
        .clk(clk),
        .rst(rst4),
        .si (si4),
        .po (po4)
    );

    sipo_reg #(
        .WIDTH      (8),
        .SHIFT_LEFT (1'b0),
        .RESET_VALUE(8'h00)
    ) dut8 (
        .clk(clk),
        .rst(rst8),
        .si (si8),
        .po (po8)
    );

    // Drive both inputs of the 4-bit instance on a falling edge, then wait
    // until just after the following rising edge.
    task automatic step4(input logic r, input logic s);
        @(negedge clk);
        rst4 = r;
        si4  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic r, input logic s);
        @(negedge clk);
        rst8 = r;
        si8  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #50;
        rst4 = 1'b1;
        rst8 = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (po4 !== 4'b0000) $display("FAIL reset_w4 po=%b required=%b", po4, 4'b0000);
        else n_pass++;
        n_total++;
        if (po8 !== 8'h00) $display("FAIL reset_w8 po=%b required=%b", po8, 8'h00);
        else n_pass++;
        @(negedge clk);
        rst8 = 1'b0;
        si8  = 1'b0;
    endtask

    task automatic test_stream();
        logic       s_tab [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] e_tab [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0110,
                                  4'b1100, 4'b1001, 4'b0011, 4'b0110};
        for (int i = 0; i < 8; i++) begin
            step4(1'b0, s_tab[i]);
            n_total++;
            if (po4 !== e_tab[i]) $display("FAIL stream[%0d] po=%b required=%b", i, po4, e_tab[i]);
            else n_pass++;
        end
    endtask

    // Continues from po=0110 left by the directed stream.
    task automatic test_fill_flush();
        logic [3:0] e_tab [8] = '{4'b1101, 4'b1011, 4'b0111, 4'b1111,
                                  4'b1110, 4'b1100, 4'b1000, 4'b0000};
        for (int i = 0; i < 8; i++) begin
            step4(1'b0, (i < 4) ? 1'b1 : 1'b0);
            n_total++;
            if (po4 !== e_tab[i]) $display("FAIL fill_flush[%0d] po=%b required=%b", i, po4, e_tab[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_priority();
        logic       s_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0] e_tab [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        for (int i = 0; i < 4; i++) begin
            step4(1'b0, s_tab[i]);
            n_total++;
            if (po4 !== e_tab[i]) $display("FAIL preload[%0d] po=%b required=%b", i, po4, e_tab[i]);
            else n_pass++;
        end
        step4(1'b1, 1'b1);
        n_total++;
        if (po4 !== 4'b0000) $display("FAIL rst_priority po=%b required=%b", po4, 4'b0000);
        else n_pass++;
        step4(1'b0, 1'b1);
        n_total++;
        if (po4 !== 4'b0001) $display("FAIL rst_resume po=%b required=%b", po4, 4'b0001);
        else n_pass++;
        step4(1'b0, 1'b0);
        n_total++;
        if (po4 !== 4'b0010) $display("FAIL rst_resume2 po=%b required=%b", po4, 4'b0010);
        else n_pass++;
    endtask

    task automatic test_variant_w8_right();
        logic [7:0] e_tab [8] = '{8'b10000000, 8'b01000000, 8'b00100000, 8'b00010000,
                                  8'b00001000, 8'b00000100, 8'b00000010, 8'b00000001};
        step8(1'b1, 1'b1);
        n_total++;
        if (po8 !== 8'h00) $display("FAIL w8_reset po=%b required=%b", po8, 8'h00);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            step8(1'b0, (i == 0) ? 1'b1 : 1'b0);
            n_total++;
            if (po8 !== e_tab[i]) $display("FAIL w8_shift[%0d] po=%b required=%b", i, po8, e_tab[i]);
            else n_pass++;
        end
        step8(1'b0, 1'b0);
        n_total++;
        if (po8 !== 8'h00) $display("FAIL w8_drop po=%b required=%b", po8, 8'h00);
        else n_pass++;
    endtask

    initial begin
        rst4 = 1'b0;
        si4  = 1'b0;
        rst8 = 1'b0;
        si8  = 1'b0;
        test_reset();
        test_stream();
        test_fill_flush();
        test_reset_priority();
        test_variant_w8_right();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_sipo_reg

// File: doc/sipo_reg.md
# sipo_reg

Serial-in, parallel-out shift register. Captures one serial bit per clock and presents the most recent WIDTH bits as a parallel word. It is a leaf block used wherever a serial bit stream must be collected into a parallel word. There is no framing, handshake or valid signalling; the consumer samples po whenever it needs to.

## Interface

Parameters:
- WIDTH, 4, number of stages and width of po; legal range ≥ 2.
- SHIFT_LEFT, 1, shift direction.
  - 1: the new bit enters po[0] and older bits move toward po[WIDTH-1].
  - 0: the new bit enters po[WIDTH-1] and older bits move toward po[0].
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into po by reset.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- si  input  1  serial data in, sampled on every rising edge of clk.
- po  output  WIDTH  parallel data out, driven directly from the shift register flops.

## Operation

- Reset:
  - On a rising edge with rst=1, po <= RESET_VALUE (0000 by default).
  - Reset has priority; si is ignored on that edge.
- Shift:
  - On every rising edge with rst=0 the register shifts by one position. There is no enable.
  - SHIFT_LEFT=1: po <= {po[WIDTH-2:0], si}.
  - SHIFT_LEFT=0: po <= {si, po[WIDTH-1:1]}.
  - The oldest bit is discarded. There is no overflow or wrap-around.
- Before the first reset edge, po is undefined (X in simulation). The system must apply reset before using po.
- Reset asserted mid-stream clears all collected bits on that edge. Shifting resumes on the first edge with rst=0.

## Timing

- Latency:
  - A bit on si appears in the entry position of po one clock edge after sampling.
  - It reaches the far end (po[WIDTH-1] when SHIFT_LEFT=1) after WIDTH edges.
  - After that it is dropped on the next edge.
- po changes only on rising clk edges. There is no combinational path from si or rst to po.
- si and rst must meet setup and hold time to clk. The bench drives them away from the rising edge.
- Throughput: one bit per cycle, continuous.

## Structure

- Single module sipo_reg containing one always block with a WIDTH-bit register.
- No sub-module is needed. Per-bit flop instances are not used.
- Shared package: none required. If the project package exists, only a default-width constant (4) may live there.

## Test plan

Common setup for all scenarios: WIDTH=4, SHIFT_LEFT=1, clock period 10 ns, rising edges at 5, 15, 25 ns and so on.

1. Power-up and reset:
   - Stimulus: hold rst=0, si=0 until 50 ns; rst=1 from 50 to 60 ns.
   - Required: po is X before the edge at 55 ns and 0000 after it.
2. Directed stream:
   - Stimulus: after reset, drive si = 0, 1, 1, 0, 0, 1, 1, 0 on successive edges from 65 ns.
   - Required po after each edge: 0000, 0001, 0011, 0110, 1100, 1001, 0011, 0110.
3. Fill and flush:
   - Stimulus: shift in four 1s, then four 0s.
   - Required: po = 1111 after the fourth edge and 0000 after the eighth. Each intermediate value is a one-position shift of the previous one.
4. Reset priority mid-stream:
   - Stimulus: with po=1011, assert rst=1 together with si=1 for one edge.
   - Required: po=0000. With rst=0 and si=1 on the next edge, po=0001.
5. Parameter variants:
   - Stimulus: WIDTH=8, SHIFT_LEFT=0; shift in 1 followed by seven 0s.
   - Required: po=10000000 after the first edge and 00000001 after the eighth.
